// File: rtl/bf_sched_if.sv
//==============================================================================
// Module   : bf_sched_if
// Desc     : Handshake bundle between bf_sched and host / relax / cycle-detect.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface bf_sched_if #(
  parameter int NODES    = 16,
  parameter int WEIGHT_W = 32
);
  localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;

  logic                      start;
  logic                      update_valid;
  logic                      vinit_we;
  logic [IDX_W-1:0]          vinit_addr;
  logic [IDX_W+WEIGHT_W-1:0] vinit_data;
  logic                      relax_reset;
  logic                      relax_done;
  logic                      relax_changed;
  logic                      cycle_reset;
  logic                      cycle_done;
  logic                      busy;
  logic [IDX_W-1:0]          pass_cnt;
  logic                      run_done;
  logic                      timeout_err;

  modport master (
    input  start, update_valid, relax_done, relax_changed, cycle_done,
    output vinit_we, vinit_addr, vinit_data, relax_reset, cycle_reset,
           busy, pass_cnt, run_done, timeout_err
  );

  modport slave (
    output start, update_valid, relax_done, relax_changed, cycle_done,
    input  vinit_we, vinit_addr, vinit_data, relax_reset, cycle_reset,
           busy, pass_cnt, run_done, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/bf_sched.sv
//==============================================================================
// Module   : bf_sched
// Desc     : Bellman-Ford run sequencer: vertex init, NODES-1 relax passes,
//            negative-cycle detect. Optional macro: BF_EARLY_EXIT_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module bf_sched #(
  parameter int NODES    = 16,
  parameter int WEIGHT_W = 32,
  parameter int SRC      = 0,
  parameter int TIMEOUT  = 4 * NODES * NODES
) (
  input  wire logic  clk,
  input  wire logic  sched_reset,
  bf_sched_if.master bus
);
  localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NODES - 1);
  localparam logic [IDX_W-1:0]    SRC_IDX  = IDX_W'(SRC);
  localparam logic [WEIGHT_W-1:0] INF      = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WD_W-1:0]     WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT       = 3'd1,
    S_RELAX_KICK = 3'd2,
    S_RELAX_WAIT = 3'd3,
    S_CYCLE_KICK = 3'd4,
    S_CYCLE_WAIT = 3'd5,
    S_FINISH     = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          pass_cnt_q, pass_cnt_d;
  logic [IDX_W-1:0]          vinit_addr_q, vinit_addr_d;
  logic [IDX_W+WEIGHT_W-1:0] vinit_data_q, vinit_data_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      pending_q, pending_d;
  logic                      timeout_err_q, timeout_err_d;
  logic                      vinit_we_q, vinit_we_d;
  logic                      relax_reset_q, relax_reset_d;
  logic                      cycle_reset_q, cycle_reset_d;
  logic                      busy_q, busy_d;
  logic                      run_done_q, run_done_d;

  logic                      w_early_exit;
  logic [WD_W-1:0]           w_wd_inc;
  logic [IDX_W-1:0]          w_pass_inc;
  logic [WEIGHT_W-1:0]       w_weight;

`ifdef BF_EARLY_EXIT_EN
  // A pass that changed nothing means the distances have already converged.
  assign w_early_exit = ~bus.relax_changed;
`else
  assign w_early_exit = 1'b0;
`endif

  assign w_wd_inc   = wd_q + 1'b1;
  assign w_pass_inc = pass_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    pass_cnt_d    = pass_cnt_q;
    pending_d     = pending_q;
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
    vinit_addr_d  = '0;

    if (state_q != S_IDLE && bus.update_valid) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_INIT;
          pass_cnt_d    = '0;
          timeout_err_d = 1'b0;
          pending_d     = 1'b0;
        end
      end
      S_INIT: begin
        if (vinit_addr_q == LAST_IDX)
          state_d = (NODES == 1) ? S_CYCLE_KICK : S_RELAX_KICK;
        else
          vinit_addr_d = vinit_addr_q + 1'b1;
      end
      S_RELAX_KICK: begin
        state_d = S_RELAX_WAIT;
        wd_d    = '0;
      end
      S_RELAX_WAIT: begin
        if (bus.relax_done) begin
          pass_cnt_d = (pass_cnt_q == LAST_IDX) ? pass_cnt_q : w_pass_inc;
          state_d    = (w_pass_inc == LAST_IDX || w_early_exit) ? S_CYCLE_KICK : S_RELAX_KICK;
        end else if (w_wd_inc == WD_LIMIT) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
          pending_d     = 1'b0;
        end else begin
          wd_d = w_wd_inc;
        end
      end
      S_CYCLE_KICK: begin
        state_d = S_CYCLE_WAIT;
        wd_d    = '0;
      end
      S_CYCLE_WAIT: begin
        if (bus.cycle_done) begin
          state_d = S_FINISH;
        end else if (w_wd_inc == WD_LIMIT) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
          pending_d     = 1'b0;
        end else begin
          wd_d = w_wd_inc;
        end
      end
      S_FINISH: begin
        // An update arriving in this very cycle still forces a rerun.
        if (pending_q || bus.update_valid) begin
          state_d    = S_INIT;
          pending_d  = 1'b0;
          pass_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    w_weight      = (vinit_addr_d == SRC_IDX) ? {WEIGHT_W{1'b0}} : INF;
    vinit_we_d    = (state_d == S_INIT);
    vinit_data_d  = vinit_we_d ? {vinit_addr_d, w_weight} : '0;
    relax_reset_d = (state_d == S_RELAX_KICK);
    cycle_reset_d = (state_d == S_CYCLE_KICK);
    busy_d        = (state_d != S_IDLE);
    run_done_d    = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (sched_reset) begin
      state_q       <= S_IDLE;
      pass_cnt_q    <= '0;
      vinit_addr_q  <= '0;
      vinit_data_q  <= '0;
      wd_q          <= '0;
      pending_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      vinit_we_q    <= 1'b0;
      relax_reset_q <= 1'b0;
      cycle_reset_q <= 1'b0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pass_cnt_q    <= pass_cnt_d;
      vinit_addr_q  <= vinit_addr_d;
      vinit_data_q  <= vinit_data_d;
      wd_q          <= wd_d;
      pending_q     <= pending_d;
      timeout_err_q <= timeout_err_d;
      vinit_we_q    <= vinit_we_d;
      relax_reset_q <= relax_reset_d;
      cycle_reset_q <= cycle_reset_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
    end
  end

  assign bus.vinit_we    = vinit_we_q;
  assign bus.vinit_addr  = vinit_addr_q;
  assign bus.vinit_data  = vinit_data_q;
  assign bus.relax_reset = relax_reset_q;
  assign bus.cycle_reset = cycle_reset_q;
  assign bus.busy        = busy_q;
  assign bus.pass_cnt    = pass_cnt_q;
  assign bus.run_done    = run_done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bf_sched.sv
//==============================================================================
// Module   : tb_bf_sched
// Desc     : Scoreboard bench for bf_sched with simple relax / cycle-detect models.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_bf_sched;
  localparam int NODES    = 4;
  localparam int WEIGHT_W = 32;
  localparam int TIMEOUT  = 64;
  localparam int DATA_W   = 2 + WEIGHT_W;
`ifdef BF_EARLY_EXIT_EN
  localparam int EARLY_PASSES = 1;
`else
  localparam int EARLY_PASSES = 3;
`endif
  localparam logic [3:0] K_INIT  = 4'd1;
  localparam logic [3:0] K_RELAX = 4'd2;
  localparam logic [3:0] K_CYCLE = 4'd3;
  localparam logic [3:0] K_DONE  = 4'd4;

  typedef struct packed {
    int                cyc;
    logic [3:0]        kind;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic sched_reset;
  int   cyc        = 0;
  int   errors     = 0;
  int   checks     = 0;
  int   kick_total = 0;
  int   zero_kick  = 0;
  int   rcnt       = 0;
  int   ccnt       = 0;
  bit   hang       = 1'b0;
  ev_t  exp_q[$];

  bf_sched_if #(.NODES(NODES), .WEIGHT_W(WEIGHT_W)) u ();

  bf_sched #(.NODES(NODES), .WEIGHT_W(WEIGHT_W), .SRC(0), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .sched_reset (sched_reset),
    .bus         (u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Relax engine: done 5 cycles after each kick; changed=0 only on kick number zero_kick.
  always @(posedge clk) begin
    if (sched_reset) begin
      u.relax_done    <= 1'b0;
      u.relax_changed <= 1'b0;
      rcnt            <= 0;
    end else if (u.relax_reset) begin
      u.relax_done    <= 1'b0;
      rcnt            <= 5;
      kick_total      <= kick_total + 1;
      u.relax_changed <= (kick_total + 1 != zero_kick);
    end else if (rcnt != 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1 && !hang) u.relax_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (sched_reset) begin
      u.cycle_done <= 1'b0;
      ccnt         <= 0;
    end else if (u.cycle_reset) begin
      u.cycle_done <= 1'b0;
      ccnt         <= 3;
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) u.cycle_done <= 1'b1;
    end
  end

  function automatic void push_ev(input int c, input logic [3:0] k, input logic [1:0] a);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.addr = a;
    e.data = (k == K_INIT) ? {a, ((a == 2'd0) ? 32'h0000_0000 : 32'h7FFF_FFFF)} : '0;
    exp_q.push_back(e);
  endfunction

  // t0 < 0 leaves event cycles unchecked; otherwise t0 is the start cycle.
  function automatic void push_run(input int t0, input int passes);
    for (int i = 0; i < NODES; i++) push_ev((t0 < 0) ? -1 : t0 + 1 + i, K_INIT, 2'(i));
    for (int p = 0; p < passes; p++) push_ev((p == 0 && t0 >= 0) ? t0 + NODES + 1 : -1, K_RELAX, 2'd0);
    push_ev(-1, K_CYCLE, 2'd0);
    push_ev(-1, K_DONE, 2'd0);
  endfunction

  task automatic tick();
    logic [3:0] kind;
    ev_t        e;
    @(negedge clk);
    if (u.vinit_we || u.relax_reset || u.cycle_reset || u.run_done) begin
      checks++;
      if ($countones({u.vinit_we, u.relax_reset, u.cycle_reset, u.run_done}) != 1) begin
        errors++;
        $display("FAIL exclusive_strobes: cycle %0d got we/rr/cr/done=%b, required exactly one",
                 cyc, {u.vinit_we, u.relax_reset, u.cycle_reset, u.run_done});
      end else begin
        kind = u.vinit_we ? K_INIT : u.relax_reset ? K_RELAX : u.cycle_reset ? K_CYCLE : K_DONE;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cycle %0d got kind %0d, required none", cyc, kind);
        end else begin
          e = exp_q.pop_front();
          if (kind !== e.kind || (e.cyc >= 0 && cyc != e.cyc) ||
              (kind == K_INIT && (u.vinit_addr !== e.addr || u.vinit_data !== e.data))) begin
            errors++;
            $display("FAIL event: cycle %0d got kind=%0d addr=%0d data=%h, required kind=%0d addr=%0d data=%h cycle=%0d",
                     cyc, kind, u.vinit_addr, u.vinit_data, e.kind, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic pulse_start();
    u.start = 1'b1;
    tick();
    u.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (u.busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (u.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, u.busy, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_events: %0d expected events still outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_kick(input string name, output int k);
    int n = 0;
    while (u.relax_reset !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    k = cyc;
    checks++;
    if (u.relax_reset !== 1'b1) begin
      errors++;
      $display("FAIL %s_kick: relax_reset=%b after %0d cycles, required 1", name, u.relax_reset, n);
    end
  endtask

  task automatic test_reset();
    sched_reset    = 1'b1;
    u.start        = 1'b0;
    u.update_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({u.busy, u.vinit_we, u.relax_reset, u.cycle_reset, u.run_done, u.timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000",
               {u.busy, u.vinit_we, u.relax_reset, u.cycle_reset, u.run_done, u.timeout_err});
    end
    checks++;
    if (u.pass_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_pass_cnt: got %0d, required 0", u.pass_cnt);
    end
    checks++;
    if (u.vinit_addr !== 2'd0 || u.vinit_data !== '0) begin
      errors++;
      $display("FAIL reset_vinit: got addr=%0d data=%h, required 0", u.vinit_addr, u.vinit_data);
    end
    sched_reset = 1'b0;
    tick();
  endtask

  task automatic test_normal_run();
    zero_kick = 0;
    push_run(cyc, NODES - 1);
    pulse_start();
    wait_idle("normal");
    checks++;
    if (u.pass_cnt !== 2'd3) begin
      errors++;
      $display("FAIL normal_pass_cnt: got %0d, required 3", u.pass_cnt);
    end
  endtask

  task automatic test_early_exit();
    zero_kick = kick_total + 1;
    push_run(cyc, EARLY_PASSES);
    pulse_start();
    wait_idle("early");
    checks++;
    if (u.pass_cnt !== 2'(EARLY_PASSES)) begin
      errors++;
      $display("FAIL early_pass_cnt: got %0d, required %0d", u.pass_cnt, EARLY_PASSES);
    end
    zero_kick = 0;
  endtask

  task automatic test_rerun();
    int k;
    int n = 0;
    push_run(cyc, NODES - 1);
    push_run(-1, NODES - 1);
    pulse_start();
    wait_kick("rerun", k);
    tick();
    u.update_valid = 1'b1;
    tick();
    u.update_valid = 1'b0;
    while (u.run_done !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (u.run_done !== 1'b1) begin
      errors++;
      $display("FAIL rerun_first_done: run_done=%b after %0d cycles, required 1", u.run_done, n);
    end
    tick();
    checks++;
    if (u.busy !== 1'b1 || u.vinit_we !== 1'b1 || u.vinit_addr !== 2'd0 || u.pass_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rerun_restart: got busy=%b we=%b addr=%0d pass=%0d, required 1 1 0 0",
               u.busy, u.vinit_we, u.vinit_addr, u.pass_cnt);
    end
    wait_idle("rerun");
    checks++;
    if (u.pass_cnt !== 2'd3) begin
      errors++;
      $display("FAIL rerun_pass_cnt: got %0d, required 3", u.pass_cnt);
    end
  endtask

  task automatic test_timeout();
    int k;
    int n = 0;
    hang = 1'b1;
    for (int i = 0; i < NODES; i++) push_ev(cyc + 1 + i, K_INIT, 2'(i));
    push_ev(cyc + NODES + 1, K_RELAX, 2'd0);
    pulse_start();
    wait_kick("timeout", k);
    while (u.timeout_err !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (u.timeout_err !== 1'b1 || cyc - k != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_fire: timeout_err=%b at %0d cycles after kick, required 1 at %0d",
               u.timeout_err, cyc - k, TIMEOUT + 1);
    end
    checks++;
    if (u.busy !== 1'b0 || u.run_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b run_done=%b, required 0 0", u.busy, u.run_done);
    end
    repeat (4) tick();
    checks++;
    if (u.timeout_err !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b pending_events=%0d, required 1 0", u.timeout_err, exp_q.size());
    end
    hang = 1'b0;
    push_run(cyc, NODES - 1);
    pulse_start();
    checks++;
    if (u.timeout_err !== 1'b0 || u.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: got err=%b busy=%b, required 0 1", u.timeout_err, u.busy);
    end
    wait_idle("after_timeout");
  endtask

  task automatic test_reset_mid_run();
    int k;
    push_ev(cyc + 1, K_INIT, 2'd0);
    push_ev(cyc + 2, K_INIT, 2'd1);
    push_ev(cyc + 3, K_INIT, 2'd2);
    push_ev(cyc + 4, K_INIT, 2'd3);
    push_ev(cyc + 5, K_RELAX, 2'd0);
    push_ev(-1, K_RELAX, 2'd0);
    pulse_start();
    wait_kick("midreset1", k);
    tick();
    wait_kick("midreset2", k);
    repeat (2) tick();
    sched_reset = 1'b1;
    u.start     = 1'b1;
    tick();
    sched_reset = 1'b0;
    u.start     = 1'b0;
    checks++;
    if ({u.busy, u.vinit_we, u.relax_reset, u.cycle_reset, u.run_done, u.timeout_err} !== 6'b0 ||
        u.pass_cnt !== 2'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_outputs: got flags=%b pass=%0d events=%0d, required 0 0 0",
               {u.busy, u.vinit_we, u.relax_reset, u.cycle_reset, u.run_done, u.timeout_err},
               u.pass_cnt, exp_q.size());
    end
    push_run(cyc, NODES - 1);
    pulse_start();
    wait_idle("post_reset");
    checks++;
    if (u.pass_cnt !== 2'd3) begin
      errors++;
      $display("FAIL post_reset_pass_cnt: got %0d, required 3", u.pass_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_early_exit();
    test_rerun();
    test_timeout();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
